// File: rtl/lsu_pkg.sv
// lsu_pkg: shared encodings and helpers for the load/store unit
// Holds wordmode encodings, exception codes, FSM states, timeout limit,
// plus byte-enable and store-steering helpers.
package lsu_pkg;
  localparam logic [2:0] wm_wd = 3'd0;
  localparam logic [2:0] wm_hs = 3'd1;
  localparam logic [2:0] wm_hu = 3'd2;
  localparam logic [2:0] wm_bs = 3'd3;
  localparam logic [2:0] wm_bu = 3'd4;
  localparam logic [4:0] exc_ld_mis = 5'd4;
  localparam logic [4:0] exc_st_mis = 5'd5;
  localparam logic [4:0] exc_tmo = 5'd7;
  localparam logic [4:0] exc_ill = 5'd10;
  localparam logic [7:0] tmo_limit = 8'd255;
  typedef enum logic [1:0] {s_idle = 2'd0, s_req = 2'd1, s_resp = 2'd2} state_t;
  function automatic logic is_half(input logic [2:0] wm);
    return wm == wm_hs || wm == wm_hu;
  endfunction
  function automatic logic [3:0] be_of(input logic [2:0] wm, input logic [1:0] off);
    return wm == wm_wd ? 4'hf : is_half(wm) ? (off[1] ? 4'hc : 4'h3) : 4'b0001 << off;
  endfunction
  function automatic logic [31:0] steer(input logic [2:0] wm, input logic [31:0] d);
    return wm == wm_wd ? d : is_half(wm) ? {2{d[15:0]}} : {4{d[7:0]}};
  endfunction
endpackage

// File: rtl/lsu_ctrl_ld_ext.sv
// lsu_ld_ext: load lane select and sign/zero extension
// Ports: wm (wordmode), off (byte offset), data (raw memory word), ext (extended result).
module lsu_ld_ext
  import lsu_pkg::*;
(
  input  logic [2:0]  wm,
  input  logic [1:0]  off,
  input  logic [31:0] data,
  output logic [31:0] ext
);
  logic [15:0] h;
  logic [7:0]  b;
  always_comb begin
    h = off[1] ? data[31:16] : data[15:0];
    b = data[{off, 3'b000} +: 8];
    ext = wm == wm_wd ? data :
          wm == wm_hs ? {{16{h[15]}}, h} :
          wm == wm_hu ? {16'b0, h} :
          wm == wm_bs ? {{24{b[7]}}, b} : {24'b0, b};
  end
endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: MEM-stage load/store controller (IDLE -> REQ -> RESP handshake)
// Pipeline side: req, we, wordmode, addr, wdata in; stall, rdata, done, exc, exc_code out.
// Memory side: mem_req, mem_we, mem_be, mem_addr, mem_wdata out; mem_rdata, mem_ack in.
// Define LSU_TIMEOUT_EN to abort a REQ after tmo_limit cycles without mem_ack.
module lsu_ctrl
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [2:0]  wordmode,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        done,
  output logic        exc,
  output logic [4:0]  exc_code,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);
  state_t      state;
  logic        lat_we;
  logic [2:0]  lat_wm;
  logic [1:0]  lat_off;
  logic [31:0] lat_addr, lat_wdata, ext;
  logic [3:0]  lat_be;
  logic        ill, mis, idle_req, go, expire, tmo;
  lsu_ld_ext u_ext (.wm(lat_wm), .off(lat_off), .data(mem_rdata), .ext(ext));
  always_comb begin
    ill = wordmode > wm_bu || (we && (wordmode == wm_hu || wordmode == wm_bu));
    mis = (wordmode == wm_wd && addr[1:0] != 2'b00) || (is_half(wordmode) && addr[0]);
    idle_req = state == s_idle && req && !reset;
    go = idle_req && !ill && !mis;
  end
`ifdef LSU_TIMEOUT_EN
  logic [7:0] cnt;
  assign expire = cnt == tmo_limit - 8'd1;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cnt <= '0;
      tmo <= 1'b0;
    end else if (go) begin
      cnt <= '0;
      tmo <= 1'b0;
    end else if (state == s_req) begin
      cnt <= cnt + 8'd1;
      tmo <= !mem_ack && expire;
    end
`else
  assign expire = 1'b0;
  assign tmo = 1'b0;
`endif
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= s_idle;
      lat_we <= 1'b0;
      lat_wm <= '0;
      lat_off <= '0;
      lat_addr <= '0;
      lat_wdata <= '0;
      lat_be <= '0;
      rdata <= '0;
    end else if (go) begin
      state <= s_req;
      lat_we <= we;
      lat_wm <= wordmode;
      lat_off <= addr[1:0];
      lat_addr <= {addr[31:2], 2'b00};
      lat_wdata <= steer(wordmode, wdata);
      lat_be <= be_of(wordmode, addr[1:0]);
    end else if (state == s_req && (mem_ack || expire)) begin
      state <= s_resp;
      rdata <= mem_ack && !lat_we ? ext : '0;
    end else if (state == s_resp)
      state <= s_idle;
  always_comb begin
    stall = go || state == s_req;
    done = state == s_resp;
    exc = (idle_req && (ill || mis)) || (done && tmo);
    exc_code = !exc ? 5'd0 : done ? exc_tmo : ill ? exc_ill : we ? exc_st_mis : exc_ld_mis;
    mem_req = state == s_req;
    mem_we = mem_req && lat_we;
    mem_be = mem_req ? lat_be : 4'b0;
    mem_addr = mem_req ? lat_addr : '0;
    mem_wdata = mem_req ? lat_wdata : '0;
  end
endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: scoreboard bench for lsu_ctrl with directed load/store/fault vectors
module tb_lsu_ctrl;
  logic        clk = 0, reset = 1, req = 0, we = 0, mem_ack = 0;
  logic [2:0]  wordmode = 0;
  logic [31:0] addr = 0, wdata = 0, mem_rdata = 0;
  logic        stall, done, exc, mem_req, mem_we;
  logic [31:0] rdata, mem_addr, mem_wdata;
  logic [4:0]  exc_code;
  logic [3:0]  mem_be;
  int checks = 0, failures = 0;
  typedef struct packed {
    logic [31:0] rdata;
    logic        exc;
    logic [4:0]  code;
    logic        chk_rd;
  } exp_t;
  exp_t q[$];

  lsu_ctrl dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .wordmode(wordmode), .addr(addr),
    .wdata(wdata), .stall(stall), .rdata(rdata), .done(done), .exc(exc),
    .exc_code(exc_code), .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk)
    if (!reset && (done || exc)) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output done=%0b exc=%0b code=%0d t=%0t", done, exc, exc_code, $time);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("resp_exc", {31'b0, exc}, {31'b0, e.exc});
        chk("resp_code", {27'b0, exc_code}, {27'b0, e.code});
        if (e.chk_rd) chk("resp_rdata", rdata, e.rdata);
      end
    end

  task automatic op(input logic w, input logic [2:0] wm, input logic [31:0] a, input logic [31:0] wd,
                    input logic [31:0] mrd, input int k, input logic [3:0] ebe,
                    input logic [31:0] ewd, input logic [31:0] erd);
    q.push_back('{erd, 1'b0, 5'd0, 1'b1});
    req = 1; we = w; wordmode = wm; addr = a; wdata = wd;
    @(negedge clk);
    chk("start_stall", {31'b0, stall}, 1);
    chk("start_mem_req", {31'b0, mem_req}, 0);
    @(posedge clk); #1;
    we = ~w; wordmode = 3'd7; addr = 32'hFFFF_FFFF; wdata = 32'hFFFF_FFFF;
    for (int c = 1; c <= k; c++) begin
      mem_ack = c == k;
      mem_rdata = mrd;
      @(negedge clk);
      chk("req_mem_req", {31'b0, mem_req}, 1);
      chk("req_stall", {31'b0, stall}, 1);
      chk("req_mem_we", {31'b0, mem_we}, {31'b0, w});
      chk("req_mem_be", {28'b0, mem_be}, {28'b0, ebe});
      chk("req_mem_addr", mem_addr, {a[31:2], 2'b00});
      chk("req_mem_wdata", mem_wdata, ewd);
      @(posedge clk); #1;
    end
    req = 0; mem_ack = 0; mem_rdata = 32'h0BAD_0BAD;
    @(negedge clk);
    chk("resp_done", {31'b0, done}, 1);
    chk("resp_stall", {31'b0, stall}, 0);
    chk("resp_mem_req", {31'b0, mem_req}, 0);
    @(posedge clk); #1;
  endtask

  task automatic bad(input logic w, input logic [2:0] wm, input logic [31:0] a, input logic [4:0] code);
    q.push_back('{32'd0, 1'b1, code, 1'b0});
    req = 1; we = w; wordmode = wm; addr = a;
    @(negedge clk);
    chk("fault_stall", {31'b0, stall}, 0);
    chk("fault_mem_req", {31'b0, mem_req}, 0);
    @(posedge clk); #1;
    req = 0;
    @(negedge clk);
    chk("fault_no_access", {31'b0, mem_req}, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    @(negedge clk);
    chk("rst_mem_req", {31'b0, mem_req}, 0);
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_exc", {31'b0, exc}, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_mem_be", {28'b0, mem_be}, 0);
    @(posedge clk); #1 reset = 0;
    op(0, 3'd3, 32'h0000_1003, 32'h55, 32'h80FF_1234, 1, 4'b1000, 32'h5555_5555, 32'hFFFF_FF80);
    op(1, 3'd1, 32'h0000_2002, 32'h1234_ABCD, 32'h0, 3, 4'b1100, 32'hABCD_ABCD, 32'h0);
    op(0, 3'd0, 32'h0000_3000, 32'h0, 32'hDEAD_BEEF, 2, 4'b1111, 32'h0, 32'hDEAD_BEEF);
    op(0, 3'd2, 32'h0000_4002, 32'h0, 32'h8001_7FFF, 1, 4'b1100, 32'h0, 32'h0000_8001);
    op(0, 3'd1, 32'h0000_4000, 32'h0, 32'h1234_8001, 2, 4'b0011, 32'h0, 32'hFFFF_8001);
    op(0, 3'd4, 32'h0000_5001, 32'h0, 32'h0000_A500, 1, 4'b0010, 32'h0, 32'h0000_00A5);
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk) chk("rdata_hold", rdata, 32'h0000_00A5);
    @(posedge clk); #1;
    op(1, 3'd3, 32'h0000_6002, 32'h77, 32'hFFFF_FFFF, 1, 4'b0100, 32'h7777_7777, 32'h0);
    op(1, 3'd0, 32'h0000_7000, 32'hCAFE_F00D, 32'h0, 2, 4'b1111, 32'hCAFE_F00D, 32'h0);
    bad(0, 3'd0, 32'h0000_0006, 5'd4);
    bad(1, 3'd1, 32'h0000_0001, 5'd5);
    bad(0, 3'd7, 32'h0000_0000, 5'd10);
    bad(1, 3'd4, 32'h0000_0000, 5'd10);
    bad(0, 3'd2, 32'h0000_0003, 5'd4);
    req = 1; we = 0; wordmode = 3'd0; addr = 32'h0000_0100;
    @(posedge clk); #1 req = 0;
    @(negedge clk) chk("mid_req_mem_req", {31'b0, mem_req}, 1);
    #1 reset = 1;
    #1;
    chk("rst_mid_mem_req", {31'b0, mem_req}, 0);
    chk("rst_mid_stall", {31'b0, stall}, 0);
    chk("rst_mid_mem_be", {28'b0, mem_be}, 0);
    @(posedge clk); #1 reset = 0; mem_ack = 1;
    repeat (3) begin
      @(negedge clk);
      chk("idle_ack_ignored", {31'b0, mem_req}, 0);
      @(posedge clk); #1;
    end
    mem_ack = 0;
    op(0, 3'd0, 32'h0000_0200, 32'h0, 32'h0102_0304, 1, 4'b1111, 32'h0, 32'h0102_0304);
    n = 0;
    req = 1; we = 0; wordmode = 3'd0; addr = 32'h0000_8000;
    @(posedge clk); #1 req = 0;
`ifdef LSU_TIMEOUT_EN
    q.push_back('{32'd0, 1'b1, 5'd7, 1'b1});
    while (n < 400) begin
      @(negedge clk);
      if (done) break;
      n++;
      @(posedge clk); #1;
    end
    chk("timeout_req_cycles", n, 255);
    @(posedge clk); #1;
`else
    repeat (300) begin
      @(negedge clk);
      if (stall && mem_req && !done) n++;
      @(posedge clk); #1;
    end
    chk("no_timeout_stall", n, 300);
    reset = 1;
    @(posedge clk); #1 reset = 0;
`endif
    repeat (3) @(posedge clk);
    chk("scoreboard_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
